// File: rtl/s3g_pkt_tx_pkg.sv
// Shared definitions for the S3G packet framer: protocol constants, the FSM
// state and phase encodings, and the packed debug view of the FSM.
package s3g_pkt_tx_pkg;

    localparam logic [7:0] S3G_SYNC  = 8'hD5;
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    // Which byte of the frame is being handled.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CRC  = 3'd4
    } state_t;

    // Sub-phase inside a byte state. ACCEPT is only used by payload bytes,
    // while the framer waits for the next byte from the payload stream.
    typedef enum logic [1:0] {
        PH_ISSUE  = 2'd0,
        PH_WAIT   = 2'd1,
        PH_GAP    = 2'd2,
        PH_ACCEPT = 2'd3
    } phase_t;

    typedef struct packed {
        state_t st;
        phase_t ph;
    } fsm_dbg_t;

endpackage

// File: rtl/s3g_pkt_tx_crc8.sv
// Combinational Maxim/iButton CRC8 step: next CRC of (crc_in, data).
// Reflected polynomial, data consumed LSB first.
module s3g_pkt_tx_crc8
    import s3g_pkt_tx_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    // Unrolled bit-serial update over the eight data bits
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC8_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/s3g_pkt_tx.sv
// S3G packet framer: sends 0xD5, LEN, PAYLOAD[0..LEN-1], CRC8 to a UART byte
// transmitter using a tx_wr / tx_done byte handshake.
//
// Handshakes:
//   payload in : a byte moves when in_valid & in_ready are both high at a clock
//                edge; in_ready is high only while the framer waits for the next
//                payload byte, and in_valid may be held low for any length of time.
//   uart out   : tx_wr pulses for one cycle with tx_data valid; tx_data is held
//                until the UART answers with tx_done, which is only honoured in
//                the WAIT phase of the current byte.
//
// After each tx_done the framer idles GAP_CYCLES clocks before the next tx_wr.
// For payload bytes the clock in which the byte is accepted counts as one of
// those idle clocks, so the spacing stays exact when in_valid is already high
// (with GAP_CYCLES=0 a payload byte necessarily costs one extra clock).
module s3g_pkt_tx
    import s3g_pkt_tx_pkg::*;
#(
    parameter int MAX_LEN    = 32,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    output logic       busy,
    output logic       done,
    output logic       err,
    output fsm_dbg_t   dbg
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0] GAP_B     = 8'(GAP_CYCLES);

    state_t     st_q, st_nxt, adv_st;
    phase_t     ph_q, ph_nxt, adv_ph;
    logic [7:0] len_q, len_nxt;
    logic [7:0] rem_q, rem_nxt;
    logic [7:0] gap_q, gap_nxt;
    logic [7:0] crc_q, crc_nxt, crc_upd;
    logic [7:0] gap_len;
    logic [7:0] tx_data_nxt;
    logic       tx_wr_nxt, in_ready_nxt, busy_nxt, done_nxt, err_nxt;
    logic       start_ok, start_bad, take_byte, next_is_pay, advance;

    s3g_pkt_tx_crc8 u_crc8 (
        .crc_in  (crc_q),
        .data    (in_data),
        .crc_out (crc_upd)
    );

    // busy also covers the done cycle, so a start there is ignored
    assign start_ok    = (st_q == ST_IDLE) && !busy && start && (len <= MAX_LEN_B);
    assign start_bad   = (st_q == ST_IDLE) && !busy && start && (len > MAX_LEN_B);
    assign take_byte   = in_ready && in_valid;
    assign next_is_pay = ((st_q == ST_LEN) && (len_q != 8'd0)) ||
                         ((st_q == ST_PAY) && (rem_q != 8'd0));
    assign gap_len     = next_is_pay ? ((GAP_B == 8'd0) ? 8'd0 : GAP_B - 8'd1) : GAP_B;
    assign advance     = (st_q != ST_IDLE) &&
                         (((ph_q == PH_WAIT) && tx_done && (gap_len == 8'd0)) ||
                          ((ph_q == PH_GAP) && (gap_q == 8'd0)));
    assign dbg         = '{st: st_q, ph: ph_q};

    // Where the frame goes once the current byte and its gap are finished
    always_comb begin
        adv_st = ST_IDLE;
        case (st_q)
            ST_SYNC: adv_st = ST_LEN;
            ST_LEN:  adv_st = (len_q == 8'd0) ? ST_CRC : ST_PAY;
            ST_PAY:  adv_st = (rem_q == 8'd0) ? ST_CRC : ST_PAY;
            default: adv_st = ST_IDLE;
        endcase
        case (adv_st)
            ST_PAY:  adv_ph = PH_ACCEPT;
            ST_IDLE: adv_ph = PH_WAIT;
            default: adv_ph = PH_ISSUE;
        endcase
    end

    // State, counters, CRC and all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            ph_q     <= PH_WAIT;
            len_q    <= 8'd0;
            rem_q    <= 8'd0;
            gap_q    <= 8'd0;
            crc_q    <= 8'd0;
            tx_data  <= 8'd0;
            tx_wr    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            st_q     <= st_nxt;
            ph_q     <= ph_nxt;
            len_q    <= len_nxt;
            rem_q    <= rem_nxt;
            gap_q    <= gap_nxt;
            crc_q    <= crc_nxt;
            tx_data  <= tx_data_nxt;
            tx_wr    <= tx_wr_nxt;
            in_ready <= in_ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // Next state, phase and counters
    always_comb begin
        st_nxt  = st_q;
        ph_nxt  = ph_q;
        len_nxt = len_q;
        rem_nxt = rem_q;
        gap_nxt = gap_q;
        if (st_q == ST_IDLE) begin
            if (start_ok) begin
                st_nxt  = ST_SYNC;
                ph_nxt  = PH_ISSUE;
                len_nxt = len;
                rem_nxt = len;
            end
        end else begin
            case (ph_q)
                PH_ISSUE: ph_nxt = PH_WAIT;
                PH_ACCEPT: begin
                    if (take_byte) begin
                        ph_nxt  = PH_ISSUE;
                        rem_nxt = rem_q - 8'd1;
                    end
                end
                PH_WAIT: begin
                    if (tx_done && (gap_len != 8'd0)) begin
                        ph_nxt  = PH_GAP;
                        gap_nxt = gap_len - 8'd1;
                    end
                end
                PH_GAP: begin
                    if (gap_q != 8'd0) begin
                        gap_nxt = gap_q - 8'd1;
                    end
                end
                default: ph_nxt = PH_WAIT;
            endcase
            if (advance) begin
                st_nxt = adv_st;
                ph_nxt = adv_ph;
            end
        end
    end

    // Next values of the registered outputs and the CRC
    always_comb begin
        tx_data_nxt = tx_data;
        crc_nxt     = crc_q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        if (st_q == ST_IDLE) begin
            busy_nxt = 1'b0;
            if (start_ok) begin
                tx_data_nxt = S3G_SYNC;
                busy_nxt    = 1'b1;
                crc_nxt     = 8'd0;
            end
            if (start_bad) begin
                err_nxt = 1'b1;
            end
        end
        if (take_byte) begin
            tx_data_nxt = in_data;
            crc_nxt     = crc_upd;
        end
        if (advance) begin
            case (adv_st)
                ST_LEN:  tx_data_nxt = len_q;
                ST_CRC:  tx_data_nxt = crc_q;
                ST_IDLE: done_nxt    = 1'b1;
                default: ;
            endcase
        end
        tx_wr_nxt    = (st_nxt != ST_IDLE) && (ph_nxt == PH_ISSUE);
        in_ready_nxt = (st_nxt == ST_PAY) && (ph_nxt == PH_ACCEPT);
    end

endmodule

// File: tb/tb_s3g_pkt_tx.sv
// Bench for s3g_pkt_tx. Two instances share the payload/UART inputs: dut_a with
// no inter-byte gap and dut_b with a 10-clock gap; sel picks which one the UART
// model and the driver talk to, the other must stay silent.
module tb_s3g_pkt_tx;
  import s3g_pkt_tx_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int GAP_B   = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_a, start_b, in_valid, tx_done, sel;
  logic [7:0] len, in_data;
  logic       in_ready_a, tx_wr_a, busy_a, done_a, err_a;
  logic       in_ready_b, tx_wr_b, busy_b, done_b, err_b;
  logic [7:0] tx_data_a, tx_data_b;
  fsm_dbg_t   dbg_a, dbg_b;

  s3g_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_a), .tx_data(tx_data_a), .tx_wr(tx_wr_a),
    .tx_done(tx_done), .busy(busy_a), .done(done_a), .err(err_a), .dbg(dbg_a)
  );

  s3g_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_b), .tx_data(tx_data_b), .tx_wr(tx_wr_b),
    .tx_done(tx_done), .busy(busy_b), .done(done_b), .err(err_b), .dbg(dbg_b)
  );

  logic       in_ready_m, tx_wr_m, busy_m, done_m, stray_wr;
  logic [7:0] tx_data_m;
  assign in_ready_m = sel ? in_ready_b : in_ready_a;
  assign tx_wr_m    = sel ? tx_wr_b : tx_wr_a;
  assign busy_m     = sel ? busy_b : busy_a;
  assign done_m     = sel ? done_b : done_a;
  assign tx_data_m  = sel ? tx_data_b : tx_data_a;
  assign stray_wr   = sel ? tx_wr_a : tx_wr_b;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         wr_cyc_q[$];
  int         txd_cyc_q[$];
  logic [7:0] pay[256];
  int         n_total = 0, n_pass = 0, n_fail = 0;
  int         lat_max = 3;
  int         wr_total = 0, stray = 0, hold_bad = 0, wr_overlap = 0;
  int         err_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic       done_busy = 1'b0;
  logic [7:0] last_crc = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: Maxim CRC8 over the first n payload bytes
  function automatic logic [7:0] crc_ref(input int n);
    logic [7:0] c = 8'h00;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = pay[i];
      for (int b = 0; b < 8; b++) begin
        if ((c[0] ^ d[b]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else c = c >> 1;
        end
    end
    return c;
  endfunction

  // UART model and monitor: logs bytes, answers each tx_wr with tx_done
  initial begin : uart_model
    int cd;
    logic [7:0] held;
    cd = 0;
    held = 8'h00;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (tx_wr_m && cd > 0) wr_overlap++;
        if (cd > 0) begin
          if (tx_data_m !== held) hold_bad++;
          cd--;
          if (cd == 0) begin
            tx_done = 1'b1;
            txd_cyc_q.push_back(cyc);
          end
        end
        if (tx_wr_m) begin
          got_q.push_back(tx_data_m);
          wr_cyc_q.push_back(cyc);
          wr_total++;
          held = tx_data_m;
          cd = $urandom_range(lat_max, 1);
        end
        if (stray_wr) stray++;
        if (err_a || err_b) err_cnt++;
        if (done_m) begin
          done_cnt++;
          done_cyc = cyc;
          done_busy = busy_m;
        end
      end
    end
  end

  // Driver: sends pay[0..n-1] through the selected instance and checks the frame.
  // rst_at >= 0 pulls reset once that many payload bytes were accepted.
  task automatic send_pkt(input int n, input int stall_at, input int stall_len,
                          input int rst_at, input bit dup_start);
    int idx, guard, it, d0, e0, g0, w0, t0, s0, st0, wr0, gap, bdrop, wt;
    logic acc;
    logic [7:0] e;
    gap = sel ? GAP_B : 0;
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(crc_ref(n));
    d0 = done_cnt; e0 = err_cnt; g0 = got_q.size(); w0 = wr_cyc_q.size();
    t0 = txd_cyc_q.size(); s0 = stray; bdrop = 0;
    len = 8'(n);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    st0 = cyc;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    idx = 0; guard = 0; it = 0;
    while (idx < n && guard < 4000) begin
      if (rst_at >= 0 && idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_tx_data", tx_data_m, 8'h00);
        check("rst_tx_wr", tx_wr_m, 1'b0);
        check("rst_in_ready", in_ready_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_done_err", {done_m, err_a, err_b}, 3'b000);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_total;
        repeat (30) @(negedge clk);
        check("rst_no_tx_wr", wr_total, wr0);
        check("rst_busy_after", busy_m, 1'b0);
        exp_q.delete();
        return;
      end
      if (stall_len > 0 && idx == stall_at) begin
        in_valid = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          if (!busy_m) bdrop++;
          @(negedge clk);
        end
        check("stall_no_tx_wr", got_q.size() - g0, 2 + stall_at);
        check("stall_in_ready", in_ready_m, 1'b1);
        stall_len = 0;
      end
      in_valid = 1'b1;
      in_data = pay[idx];
      if (dup_start && it == 4) begin
        len = 8'd2;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      acc = in_ready_m;
      if (!busy_m) bdrop++;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (acc) idx++;
      guard++; it++;
    end
    in_valid = 1'b0;
    check("payload_accepted", idx, n);
    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      if (!busy_m) bdrop++;
      @(negedge clk);
      guard++;
    end
    check("done_pulses", done_cnt - d0, 1);
    check("busy_held", bdrop, 0);
    check("busy_at_done", done_busy, 1'b1);
    check("byte_count", got_q.size() - g0, exp_q.size());
    check("first_wr_latency", (wr_cyc_q.size() > w0) ? wr_cyc_q[w0] - st0 : -1, 1);
    check("done_latency",
          (txd_cyc_q.size() > t0) ? done_cyc - txd_cyc_q[txd_cyc_q.size() - 1] : -1, 1 + gap);
    if (got_q.size() > g0) last_crc = got_q[got_q.size() - 1];
    if (sel) begin
      for (int k = 1; k < n + 3; k++) begin
        wt = (wr_cyc_q.size() > w0 + k && txd_cyc_q.size() > t0 + k - 1)
             ? wr_cyc_q[w0 + k] - txd_cyc_q[t0 + k - 1] : -1;
        check($sformatf("gap_before_byte%0d", k), wt, GAP_B + 1);
      end
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      check($sformatf("byte%0d", k), (got_q.size() > g0 + k) ? {24'h0, got_q[g0 + k]} : 32'hFFFF_FFFF, e);
    end
    @(negedge clk);
    check("busy_cleared", busy_m, 1'b0);
    wr0 = wr_total;
    repeat (40) @(negedge clk);
    check("idle_no_tx_wr", wr_total, wr0);
    check("no_err", err_cnt - e0, 0);
    check("other_silent", stray - s0, 0);
    check("tx_data_held", hold_bad, 0);
    check("wr_before_done", wr_overlap, 0);
  endtask

  initial begin
    int e0, wr0, n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; len = 8'h00;
    in_data = 8'h00; in_valid = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {tx_data_a, tx_wr_a, in_ready_a, busy_a, done_a, err_a}, 13'h0);
    check("reset_outputs_b", {tx_data_b, tx_wr_b, in_ready_b, busy_b, done_b, err_b}, 13'h0);
    check("reset_state_a", dbg_a.st, ST_IDLE);
    check("reset_state_b", dbg_b.st, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 12 34 85, no gap
    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h85;
    send_pkt(3, -1, 0, -1, 1'b0);
    check("t1_crc", last_crc, 8'hA0);

    // 2: five bytes
    pay[0] = 8'h80; pay[1] = 8'h81; pay[2] = 8'h81; pay[3] = 8'hBA; pay[4] = 8'hCE;
    send_pkt(5, -1, 0, -1, 1'b0);

    // 3: stream stalled for 500 clocks after the first byte
    pay[0] = 8'h23; pay[1] = 8'h45; pay[2] = 8'h81;
    send_pkt(3, 1, 500, -1, 1'b0);

    // 4: empty payload, oversize request, largest legal request
    send_pkt(0, -1, 0, -1, 1'b0);
    e0 = err_cnt; wr0 = wr_total;
    len = 8'(MAX_LEN + 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("reject_busy", busy_a, 1'b0);
    repeat (20) @(negedge clk);
    check("reject_err_pulses", err_cnt - e0, 1);
    check("reject_no_tx_wr", wr_total, wr0);
    for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom_range(255, 0));
    send_pkt(MAX_LEN, -1, 0, -1, 1'b0);

    // 5: reset during the second payload byte, then a fresh packet
    send_pkt(3, -1, 0, 1, 1'b0);
    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h85;
    send_pkt(3, -1, 0, -1, 1'b0);
    check("t5_crc", last_crc, 8'hA0);

    // random packets with random UART latency
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(MAX_LEN, 1);
      lat_max = $urandom_range(5, 1);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(255, 0));
      send_pkt(n, ($urandom_range(1, 0) == 1) ? n / 2 : -1, $urandom_range(20, 3), -1, 1'b0);
    end

    // 6: gapped instance with a second start while busy
    sel = 1'b1;
    lat_max = 3;
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom_range(255, 0));
    send_pkt(4, -1, 0, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
